// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// ALU opcode encodings are shared with the ALU and the decoder.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_op;
    } id_ex_ctrl_t;

    // All-zero bubble also encodes alu_op = ALU_ADD.
    localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand-forward select for one source register.
// EX/MEM beats MEM/WB; register x0 is never forwarded.
module id_ex_stage_fwd_mux #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [XLEN-1:0]       rs_data_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  exmem_reg_write_i,
    input  logic [XLEN-1:0]       exmem_result_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  memwb_reg_write_i,
    input  logic [XLEN-1:0]       memwb_wdata_i,
    output logic [XLEN-1:0]       data_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

    always_comb begin
        data_o = rs_data_i;
        if (exmem_hit) begin
            data_o = exmem_result_i;
        end else if (memwb_hit) begin
            data_o = memwb_wdata_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, source selects,
// load-use hazard detection, stall (hold) and flush (bubble).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_alu_src_a,
    input  logic                  id_alu_src_b,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [XLEN-1:0]       memwb_wdata,
    output logic [XLEN-1:0]       alu_A,
    output logic [XLEN-1:0]       alu_B,
    output logic [3:0]            alu_operation,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  load_use_hazard
);

    logic                  valid_q,    valid_d;
    id_ex_ctrl_t           ctrl_q,     ctrl_d;
    logic [XLEN-1:0]       pc_q,       pc_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]       imm_q,      imm_d;
    logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Flush beats stall; an invalid decode slot captures as a bubble.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d    = 1'b0;
            ctrl_d     = ID_EX_BUBBLE;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
        end else if (!stall) begin
            valid_d    = 1'b1;
            ctrl_d     = '{reg_write:  id_reg_write,
                           mem_read:   id_mem_read,
                           mem_write:  id_mem_write,
                           mem_to_reg: id_mem_to_reg,
                           alu_src_a:  id_alu_src_a,
                           alu_src_b:  id_alu_src_b,
                           alu_op:     id_alu_op};
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= ID_EX_BUBBLE;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    id_ex_stage_fwd_mux #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs_i              (rs1_q),
        .rs_data_i         (rs1_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_wdata_i     (memwb_wdata),
        .data_o            (fwd_rs1)
    );

    id_ex_stage_fwd_mux #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs_i              (rs2_q),
        .rs_data_i         (rs2_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_wdata_i     (memwb_wdata),
        .data_o            (fwd_rs2)
    );

    assign alu_A         = ctrl_q.alu_src_a ? pc_q  : fwd_rs1;
    assign alu_B         = ctrl_q.alu_src_b ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_operation = ctrl_q.alu_op;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

    // Conservative: rs2 is compared even when the decode instruction ignores it.
    assign load_use_hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                             ((rd_q == id_rs1) || (rd_q == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table plus hand-written
// reset, load-use, stall and reset-during-stall sequences.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_a, id_alu_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_wdata;
    logic [31:0] alu_A, alu_B, ex_store_data, ex_pc;
    logic [3:0]  alu_operation;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_hazard;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_op       (id_alu_op),
        .id_alu_src_a    (id_alu_src_a),
        .id_alu_src_b    (id_alu_src_b),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .stall           (stall),
        .flush           (flush),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_wdata     (memwb_wdata),
        .alu_A           (alu_A),
        .alu_B           (alu_B),
        .alu_operation   (alu_operation),
        .ex_store_data   (ex_store_data),
        .ex_pc           (ex_pc),
        .ex_rd           (ex_rd),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .load_use_hazard (load_use_hazard)
    );

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        sa, sb, rw, mr, mw, mtr, stl, fl;
        logic [4:0]  exrd;
        logic        exw;
        logic [31:0] exres;
        logic [4:0]  mwrd;
        logic        mww;
        logic [31:0] mwdata;
        logic [31:0] e_a, e_b, e_st;
        logic [3:0]  e_op;
        logic [9:0]  e_ctl; // {valid, rd, reg_write, mem_read, mem_write, mem_to_reg}
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0;
        id_alu_src_a = 0; id_alu_src_b = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        stall = 0; flush = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_wdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_A"}, alu_A, 32'h0);
        check({tag, "_alu_B"}, alu_B, 32'h0);
        check({tag, "_store"}, ex_store_data, 32'h0);
        check({tag, "_pc"}, ex_pc, 32'h0);
        check({tag, "_op"}, {28'h0, alu_operation}, 32'h0);
        check({tag, "_ctl"}, {22'h0, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
                              ex_mem_write, ex_mem_to_reg}, 32'h0);
        check({tag, "_hazard"}, {31'h0, load_use_hazard}, 32'h0);
    endtask

    initial begin
        // name v pc rs1d rs2d imm rs1 rs2 rd op sa sb rw mr mw mtr stl fl
        //      exrd exw exres mwrd mww mwdata | e_a e_b e_st e_op e_ctl
        vecs[0] = '{"imm", 1, 32'h100, 32'h10, 32'h20, 32'hFFFF_FFFC, 1, 2, 3, ALU_ADD,
                    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    32'h10, 32'hFFFF_FFFC, 32'h20, ALU_ADD, {1'b1, 5'd3, 4'b1000}};
        vecs[1] = '{"fwd_exmem", 1, 32'h104, 32'h11, 32'h22, 0, 5, 6, 4, ALU_SUB,
                    0, 0, 1, 0, 0, 0, 0, 0, 5, 1, 32'hAAAA, 5, 1, 32'hBBBB,
                    32'hAAAA, 32'h22, 32'h22, ALU_SUB, {1'b1, 5'd4, 4'b1000}};
        vecs[2] = '{"fwd_memwb", 1, 32'h104, 32'h11, 32'h22, 0, 5, 6, 4, ALU_SUB,
                    0, 0, 1, 0, 0, 0, 0, 0, 5, 0, 32'hAAAA, 5, 1, 32'hBBBB,
                    32'hBBBB, 32'h22, 32'h22, ALU_SUB, {1'b1, 5'd4, 4'b1000}};
        vecs[3] = '{"x0_nofwd", 1, 32'h108, 32'h33, 32'h22, 0, 0, 6, 4, ALU_ADD,
                    0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA, 0, 1, 32'hBBBB,
                    32'h33, 32'h22, 32'h22, ALU_ADD, {1'b1, 5'd4, 4'b1000}};
        vecs[4] = '{"pc_src", 1, 32'h200, 32'h44, 32'h55, 0, 1, 6, 2, ALU_OR,
                    1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 32'hCAFE,
                    32'h200, 32'hCAFE, 32'hCAFE, ALU_OR, {1'b1, 5'd2, 4'b1000}};
        vecs[5] = '{"invalid", 0, 32'h300, 32'h66, 32'h77, 32'h8, 1, 2, 3, ALU_SLT,
                    0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0,
                    32'h0, 32'h0, 32'h0, ALU_ADD, 10'h0};
        vecs[6] = '{"store_fwd", 1, 32'h400, 32'h88, 32'h1, 32'h14, 4, 8, 0, ALU_ADD,
                    0, 1, 0, 0, 1, 0, 0, 0, 8, 1, 32'h5555, 8, 1, 32'h6666,
                    32'h88, 32'h14, 32'h5555, ALU_ADD, {1'b1, 5'd0, 4'b0010}};
        vecs[7] = '{"stall_flush", 1, 32'h500, 32'h10, 32'h20, 32'h4, 1, 2, 3, ALU_XOR,
                    0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,
                    32'h0, 32'h0, 32'h0, ALU_ADD, 10'h0};

        // Reset with a live instruction presented at decode.
        clear_inputs();
        rst = 1; id_valid = 1; id_reg_write = 1; id_pc = 32'h44; id_alu_op = ALU_OR;
        id_rs1_data = 32'h99;
        tick();
        check_all_zero("reset1");
        tick();
        check_all_zero("reset2");
        rst = 0;

        foreach (vecs[i]) begin
            id_valid = vecs[i].v; id_pc = vecs[i].pc;
            id_rs1_data = vecs[i].rs1d; id_rs2_data = vecs[i].rs2d; id_imm = vecs[i].imm;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
            id_alu_op = vecs[i].op; id_alu_src_a = vecs[i].sa; id_alu_src_b = vecs[i].sb;
            id_reg_write = vecs[i].rw; id_mem_read = vecs[i].mr;
            id_mem_write = vecs[i].mw; id_mem_to_reg = vecs[i].mtr;
            stall = vecs[i].stl; flush = vecs[i].fl;
            exmem_rd = vecs[i].exrd; exmem_reg_write = vecs[i].exw;
            exmem_result = vecs[i].exres;
            memwb_rd = vecs[i].mwrd; memwb_reg_write = vecs[i].mww;
            memwb_wdata = vecs[i].mwdata;
            tick();
            check({vecs[i].name, "_alu_A"}, alu_A, vecs[i].e_a);
            check({vecs[i].name, "_alu_B"}, alu_B, vecs[i].e_b);
            check({vecs[i].name, "_store"}, ex_store_data, vecs[i].e_st);
            check({vecs[i].name, "_op"}, {28'h0, alu_operation}, {28'h0, vecs[i].e_op});
            check({vecs[i].name, "_ctl"}, {22'h0, ex_valid, ex_rd, ex_reg_write,
                  ex_mem_read, ex_mem_write, ex_mem_to_reg}, {22'h0, vecs[i].e_ctl});
        end

        // Load-use: lw x7 in EX, dependent instruction at decode.
        clear_inputs();
        id_valid = 1; id_rd = 7; id_rs1 = 1; id_rs1_data = 32'h1000; id_imm = 4;
        id_alu_src_b = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        check("lw_mem_read", {31'h0, ex_mem_read}, 32'h1);
        id_rs1 = 3; id_rs2 = 7; id_rd = 9; id_rs1_data = 32'h5; id_rs2_data = 32'h9999;
        id_alu_src_b = 0; id_mem_read = 0; id_mem_to_reg = 0; id_alu_op = ALU_ADD;
        #1;
        check("hazard_rs2", {31'h0, load_use_hazard}, 32'h1);
        id_valid = 0;
        #1;
        check("hazard_invalid", {31'h0, load_use_hazard}, 32'h0);
        id_valid = 1; id_rs1 = 7; id_rs2 = 2;
        #1;
        check("hazard_rs1", {31'h0, load_use_hazard}, 32'h1);
        id_rs1 = 3; id_rs2 = 7;
        flush = 1;
        tick();
        check("lu_flush_valid", {31'h0, ex_valid}, 32'h0);
        check("lu_flush_rw", {31'h0, ex_reg_write}, 32'h0);
        check("lu_flush_hazard", {31'h0, load_use_hazard}, 32'h0);
        flush = 0;
        memwb_rd = 7; memwb_reg_write = 1; memwb_wdata = 32'h1234;
        tick();
        check("lu_fwd_alu_B", alu_B, 32'h1234);
        check("lu_fwd_store", ex_store_data, 32'h1234);
        check("lu_rd", {27'h0, ex_rd}, 32'd9);

        // Stall hold for three cycles while decode changes.
        clear_inputs();
        id_valid = 1; id_pc = 32'h300; id_rs1 = 10; id_rs1_data = 32'h77;
        id_rs2 = 11; id_rs2_data = 32'h88; id_rd = 9; id_alu_op = ALU_AND; id_reg_write = 1;
        tick();
        check("stall_pre_op", {28'h0, alu_operation}, {28'h0, ALU_AND});
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h500 + 32'(i); id_rd = 5'(20 + i); id_alu_op = ALU_XOR;
            id_rs1_data = 32'hFF;
            if (i == 1) begin
                exmem_rd = 10; exmem_reg_write = 1; exmem_result = 32'hF00D;
                #1;
                check("stall_fwd_now", alu_A, 32'hF00D);
            end
            tick();
            check("stall_op", {28'h0, alu_operation}, {28'h0, ALU_AND});
            check("stall_rd", {27'h0, ex_rd}, 32'd9);
            check("stall_pc", ex_pc, 32'h300);
            check("stall_alu_A", alu_A, (i >= 1) ? 32'hF00D : 32'h77);
        end

        // Reset while stalled still bubbles.
        rst = 1;
        tick();
        rst = 0;
        check("rst_stall_valid", {31'h0, ex_valid}, 32'h0);
        check("rst_stall_pc", ex_pc, 32'h0);
        check("rst_stall_rd", {27'h0, ex_rd}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
